return_stack: RTL and testbench
===============================

Name: return_stack

Overview:
- Hardware call/return address stack that sits beside `pc` and drives its `in`/`load` pins.
- On a call, `push` saves the return address (`pc_in + 1`).
- On a return, `pop` produces a one-cycle PC load request carrying the saved address.
- Provides full/empty status and sticky error flags for the control unit and the emulator debug view.

Parameters:
- WIDTH, 16, address width; matches the PC data width.
- DEPTH, 8, number of stack entries; must be ≥ 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- push  input  1  call strobe; saves `pc_in + 1` this edge.
- pop  input  1  return strobe; emits the top entry as a PC load this edge.
- pc_in  input  WIDTH  current PC value (the PC `out` bus).
- target_out  output  WIDTH  registered return address; wired to PC `in`.
- load_out  output  1  registered one-cycle pulse; wired to PC `load`.
- top  output  WIDTH  combinational view of the top entry; 0 when empty.
- count  output  $clog2(DEPTH+1)  number of valid entries.
- empty  output  1  `count == 0`.
- full  output  1  `count == DEPTH`.
- overflow  output  1  sticky; set by a push that was dropped.
- underflow  output  1  sticky; set by a pop on an empty stack.

Behaviour:
- Reset (async, asserted any time, including mid-operation):
  - count=0, target_out=0, load_out=0, overflow=0, underflow=0 immediately.
  - Storage contents need not be cleared; `top` reads 0 because the stack is empty.
- Return address = `pc_in + 1`, truncated to WIDTH (16'hFFFF wraps to 16'h0000).
- `load_out` defaults to 0 every cycle; it is high only in the cycle following an accepted pop.
- `target_out` holds its last value when no pop is accepted.
- Decision per rising edge, based on (push, pop) sampled at that edge:
  - 0,0: no change.
  - 1,0, not full: `stack[count] <= pc_in+1`, `count+1`.
  - 1,0, full: push dropped; overflow <= 1; no other change.
  - 0,1, not empty: `target_out <= stack[count-1]`, `load_out <= 1`, `count-1`.
  - 0,1, empty: underflow <= 1; load_out stays 0; target_out unchanged.
  - 1,1, not empty (full included): swap. `target_out <= old top`, `load_out <= 1`, top entry replaced by `pc_in+1`, count unchanged, no overflow.
  - 1,1, empty: underflow <= 1, no load; the push proceeds (count becomes 1).
- Latency: a pop at edge N gives a valid `target_out`/`load_out` after edge N. PC `load` samples it at edge N+1, so the PC holds the return address after N+1.
- `top`, `empty` and `full` are combinational from `count` and storage, and update right after the edge.
- Overflow and underflow clear only on reset.
- Single-entry stack behaviour is exercised with DEPTH=2 at boundaries; no special casing is permitted.

Test Plan:
1. Reset → count=0, empty=1, full=0, top=0, load_out=0, target_out=0, both flags 0. Assert reset mid-sequence with count=3 → all return to those values asynchronously, before the next clock edge.
2. pc_in=16'h1111 push, then pc_in=16'h2000 push, then pop, pop.
   - Before pops: count=2, top=16'h2001.
   - First pop: target_out=16'h2001, load_out=1 for exactly one cycle.
   - Second pop: target_out=16'h1112.
   - Afterwards: empty=1, no flags set.
3. Push DEPTH=8 times with pc_in=16'h0010..0x17 → full=1, top=16'h0018. Push a 9th time with pc_in=16'hAAAA → count=8, top=16'h0018, overflow=1. Then 8 pops return 16'h0018 down to 16'h0011 in order.
4. Pop on empty → underflow=1, load_out=0, target_out unchanged. A subsequent push of pc_in=16'h0005 → top=16'h0006; underflow remains 1.
5. Simultaneous push+pop:
   - Stack holds 16'h0101 (count=1), pc_in=16'h0300 → target_out=16'h0101, load_out=1, count=1, top=16'h0301.
   - Repeat when full → no overflow, count=8.
6. Wrap: push with pc_in=16'hFFFF → top=16'h0000. Integration with `pc`: pop → on the next edge, `pc` out=16'h0000.

Source files
------------

// File: rtl/return_stack.sv
// Hardware call/return address stack beside the PC: push saves pc_in+1,
// pop issues a registered one-cycle PC load carrying the saved address.
module return_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           pc_in,
  output logic [WIDTH-1:0]           target_out,
  output logic                       load_out,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] ret_addr;
  logic [IW-1:0]    top_idx;
  logic [IW-1:0]    wr_idx;
  logic             do_push;
  logic             do_pop;
  logic             do_swap;
  logic             push_drop;
  logic             pop_under;

  always_comb begin
    ret_addr  = pc_in + WIDTH'(1);
    empty     = (count == '0);
    full      = (count == DEPTH_C);
    top_idx   = IW'(count - CW'(1));
    top       = empty ? '0 : mem[top_idx];

    // Push+pop on a non-empty stack replaces the top in place; on an empty
    // stack the pop underflows and the push still goes ahead.
    do_swap   = push && pop && !empty;
    do_push   = (push && !pop && !full) || (push && pop && empty);
    do_pop    = pop && !push && !empty;
    push_drop = push && !pop && full;
    pop_under = pop && empty;
    wr_idx    = do_swap ? top_idx : IW'(count);
  end

  // NOTE: storage has no reset; count alone decides validity, so stale
  // entries are never observed and the array can map onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (do_push || do_swap) begin
      mem[wr_idx] <= ret_addr;
    end
  end

  // NOTE: non-blocking assignments here so every register samples the
  // pre-edge count/top, which is what the swap path relies on.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count      <= '0;
      target_out <= '0;
      load_out   <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      load_out <= 1'b0;
      if (do_push) begin
        count <= count + CW'(1);
      end else if (do_pop) begin
        count <= count - CW'(1);
      end
      if (do_pop || do_swap) begin
        target_out <= top;
        load_out   <= 1'b1;
      end
      if (push_drop) begin
        overflow <= 1'b1;
      end
      if (pop_under) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_return_stack.sv
// Self-checking bench for return_stack: table-driven push/pop vectors plus
// hand-written sequences for async reset and PC-load integration.
module tb_return_stack;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             push = 1'b0;
  logic             pop = 1'b0;
  logic [WIDTH-1:0] pc_in = '0;
  logic [WIDTH-1:0] target_out;
  logic             load_out;
  logic [WIDTH-1:0] top;
  logic [3:0]       count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  // Minimal PC: reloads from the stack when load_out is high.
  logic [WIDTH-1:0] pc_out;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    bit          rst;
    bit          push;
    bit          pop;
    logic [15:0] pc;
    int          cnt;
    logic [15:0] top;
    logic [15:0] tgt;
    bit          load;
    bit          ov;
    bit          un;
  } vec_t;

  vec_t vecs[$];

  return_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .pc_in      (pc_in),
    .target_out (target_out),
    .load_out   (load_out),
    .top        (top),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         pc_out <= 16'h1234;
    else if (load_out) pc_out <= target_out;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic v(input bit r, input bit p, input bit q, input logic [15:0] pc,
                   input int cnt, input logic [15:0] tp, input logic [15:0] tg,
                   input bit ld, input bit ov, input bit un);
    vec_t e;
    e.rst = r; e.push = p; e.pop = q; e.pc = pc; e.cnt = cnt; e.top = tp;
    e.tgt = tg; e.load = ld; e.ov = ov; e.un = un;
    vecs.push_back(e);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
  task automatic step(input bit p, input bit q, input logic [15:0] pc);
    @(negedge clk);
    push = p; pop = q; pc_in = pc;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " count"}, 32'(count), 32'd0);
    check({tag, " empty"}, 32'(empty), 32'd1);
    check({tag, " full"}, 32'(full), 32'd0);
    check({tag, " top"}, 32'(top), 32'h0);
    check({tag, " load_out"}, 32'(load_out), 32'd0);
    check({tag, " target_out"}, 32'(target_out), 32'h0);
    check({tag, " overflow"}, 32'(overflow), 32'd0);
    check({tag, " underflow"}, 32'(underflow), 32'd0);
  endtask

  initial begin
    // Test 2: basic push/push/pop/pop
    v(0, 1, 0, 16'h1111, 1, 16'h1112, 16'h0000, 0, 0, 0);
    v(0, 1, 0, 16'h2000, 2, 16'h2001, 16'h0000, 0, 0, 0);
    v(0, 0, 1, 16'h0000, 1, 16'h1112, 16'h2001, 1, 0, 0);
    v(0, 0, 1, 16'h0000, 0, 16'h0000, 16'h1112, 1, 0, 0);
    v(0, 0, 0, 16'h0000, 0, 16'h0000, 16'h1112, 0, 0, 0);
    // Test 5: swap with one entry, then swap when full
    v(1, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0);
    v(0, 1, 0, 16'h0100, 1, 16'h0101, 16'h0000, 0, 0, 0);
    v(0, 1, 1, 16'h0300, 1, 16'h0301, 16'h0101, 1, 0, 0);
    for (int i = 0; i < 7; i++)
      v(0, 1, 0, 16'h0400 + 16'(i), i + 2, 16'h0401 + 16'(i), 16'h0101, 0, 0, 0);
    v(0, 1, 1, 16'h0500, 8, 16'h0501, 16'h0407, 1, 0, 0);
    // Test 3: fill, overflow, drain in LIFO order
    v(1, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      v(0, 1, 0, 16'h0010 + 16'(i), i + 1, 16'h0011 + 16'(i), 16'h0000, 0, 0, 0);
    v(0, 1, 0, 16'hAAAA, 8, 16'h0018, 16'h0000, 0, 1, 0);
    for (int k = 0; k < 8; k++)
      v(0, 0, 1, 16'h0000, 7 - k, (k == 7) ? 16'h0000 : 16'h0010 + 16'(7 - k),
        16'h0018 - 16'(k), 1, 1, 0);
    // Test 4: underflow, then push; underflow stays set
    v(0, 0, 1, 16'h0000, 0, 16'h0000, 16'h0011, 0, 1, 1);
    v(0, 1, 0, 16'h0005, 1, 16'h0006, 16'h0011, 0, 1, 1);
    // Push+pop on empty: underflow, no load, push proceeds
    v(0, 0, 1, 16'h0000, 0, 16'h0000, 16'h0006, 1, 1, 1);
    v(0, 1, 1, 16'h0020, 1, 16'h0021, 16'h0006, 0, 1, 1);

    // Test 1: reset state
    #2;
    check_reset_state("reset");
    @(negedge clk);
    reset = 1'b0;

    // Mid-cycle asynchronous reset with count=3 and a pending load
    step(1, 0, 16'h000A);
    step(1, 0, 16'h000B);
    step(1, 0, 16'h000C);
    step(1, 0, 16'h000D);
    step(0, 1, 16'h0000);
    check("pre-reset count", 32'(count), 32'd3);
    check("pre-reset target_out", 32'(target_out), 32'h000E);
    check("pre-reset load_out", 32'(load_out), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_reset_state("async reset");
    #1 reset = 1'b0;

    // Table-driven vectors
    foreach (vecs[i]) begin
      if (vecs[i].rst) begin
        @(negedge clk);
        reset = 1'b1;
        #1 reset = 1'b0;
      end
      if (vecs[i].push || vecs[i].pop || !vecs[i].rst)
        step(vecs[i].push, vecs[i].pop, vecs[i].pc);
      check($sformatf("row%0d count", i), 32'(count), 32'(vecs[i].cnt));
      check($sformatf("row%0d top", i), 32'(top), 32'(vecs[i].top));
      check($sformatf("row%0d target_out", i), 32'(target_out), 32'(vecs[i].tgt));
      check($sformatf("row%0d load_out", i), 32'(load_out), 32'(vecs[i].load));
      check($sformatf("row%0d overflow", i), 32'(overflow), 32'(vecs[i].ov));
      check($sformatf("row%0d underflow", i), 32'(underflow), 32'(vecs[i].un));
      check($sformatf("row%0d empty", i), 32'(empty), 32'(vecs[i].cnt == 0));
      check($sformatf("row%0d full", i), 32'(full), 32'(vecs[i].cnt == DEPTH));
    end

    // Test 6: return-address wrap and PC reload one edge after the pop
    @(negedge clk);
    reset = 1'b1;
    #1 reset = 1'b0;
    check("pc reset", 32'(pc_out), 32'h1234);
    step(1, 0, 16'hFFFF);
    check("wrap top", 32'(top), 32'h0000);
    check("wrap count", 32'(count), 32'd1);
    step(0, 1, 16'h0000);
    check("wrap load_out", 32'(load_out), 32'd1);
    check("wrap target_out", 32'(target_out), 32'h0000);
    check("pc before reload", 32'(pc_out), 32'h1234);
    step(0, 0, 16'h0000);
    check("pc after reload", 32'(pc_out), 32'h0000);
    check("load pulse ended", 32'(load_out), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
